// File: rtl/err_compute_pkg.sv
// Shared types and timing constants for the line-follower error sequencer.
// SPACING must be >= 2 because the datapath's error feedback lags one cycle.
package err_compute_pkg;

    localparam int unsigned NUM_TERMS = 8;
    localparam int unsigned SPACING   = 2;
    localparam int unsigned PIPE_LAT  = 2;
    localparam int unsigned SEL_W     = 3;
    localparam int unsigned SP_W      = (SPACING > 2) ? $clog2(SPACING) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        HOLD,
        DRAIN,
        DONE
    } err_sm_state_t;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/err_compute_tag_pipe.sv
// Shift register that delays the operand issue strobe to the datapath's accumulate stage.
// 'empty' is high when, at most, the last stage still holds a tag, so nothing fires after this cycle.
module err_compute_tag_pipe
    import err_compute_pkg::*;
#(
    parameter int unsigned DEPTH = PIPE_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic tag_in,
    output logic tag_out,
    output logic empty
);

    logic [DEPTH-1:0] r_pipe;
    logic             w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= tag_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    always_comb begin
        w_empty = ~tag_in;
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
            if (r_pipe[i]) begin
                w_empty = 1'b0;
            end
        end
    end

    assign tag_out = r_pipe[DEPTH-1];
    assign empty   = w_empty;

endmodule

// File: rtl/err_compute_sm.sv
// Sequencer for the pipelined error datapath: issues NUM_TERMS operand selects per IR frame,
// then pulses err_vld once the last delayed accumulate has landed.
module err_compute_sm
    import err_compute_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             IR_vld,
    output logic [SEL_W-1:0] sel,
    output logic             sub,
    output logic             clr_accum,
    output logic             en_accum,
    output logic             busy,
    output logic             err_vld
);

    localparam sel_t           K_LAST  = SEL_W'(NUM_TERMS - 1);
    localparam logic [SP_W-1:0] SP_LAST = SP_W'(SPACING - 2);

    err_sm_state_t   r_state, w_state_nxt;
    sel_t            r_k, w_k_nxt;
    logic [SP_W-1:0] r_sp, w_sp_nxt;
    logic            r_pend, w_pend_nxt;

    sel_t r_sel, w_sel_nxt;
    logic r_sub, w_sub_nxt;
    logic r_clr, w_clr_nxt;
    logic r_issue, w_issue_nxt;
    logic r_busy, w_busy_nxt;
    logic r_err_vld, w_err_vld_nxt;

    logic w_tag_empty;
    logic w_en_accum;

    err_compute_tag_pipe #(
        .DEPTH (PIPE_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (r_issue),
        .tag_out (w_en_accum),
        .empty   (w_tag_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_sp      <= '0;
            r_pend    <= 1'b0;
            r_sel     <= '0;
            r_sub     <= 1'b0;
            r_clr     <= 1'b0;
            r_issue   <= 1'b0;
            r_busy    <= 1'b0;
            r_err_vld <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_sp      <= w_sp_nxt;
            r_pend    <= w_pend_nxt;
            r_sel     <= w_sel_nxt;
            r_sub     <= w_sub_nxt;
            r_clr     <= w_clr_nxt;
            r_issue   <= w_issue_nxt;
            r_busy    <= w_busy_nxt;
            r_err_vld <= w_err_vld_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_sp_nxt    = r_sp;
        w_pend_nxt  = r_pend;
        unique case (r_state)
            IDLE: begin
                if (IR_vld) begin
                    w_state_nxt = ISSUE;
                    w_k_nxt     = '0;
                end
            end
            ISSUE: begin
                w_pend_nxt  = r_pend | IR_vld;
                w_sp_nxt    = '0;
                w_state_nxt = HOLD;
            end
            HOLD: begin
                w_pend_nxt = r_pend | IR_vld;
                if (r_sp == SP_LAST) begin
                    if (r_k != K_LAST) begin
                        w_k_nxt     = r_k + SEL_W'(1);
                        w_state_nxt = ISSUE;
                    end else begin
                        w_state_nxt = DRAIN;
                    end
                end else begin
                    w_sp_nxt = r_sp + SP_W'(1);
                end
            end
            DRAIN: begin
                w_pend_nxt = r_pend | IR_vld;
                if (w_tag_empty) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (r_pend || IR_vld) begin
                    w_state_nxt = ISSUE;
                    w_k_nxt     = '0;
                    w_pend_nxt  = 1'b0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with the state.
    always_comb begin
        w_issue_nxt   = (w_state_nxt == ISSUE);
        w_sel_nxt     = w_issue_nxt ? w_k_nxt : r_sel;
        w_sub_nxt     = w_issue_nxt ? w_k_nxt[0] : r_sub;
        w_clr_nxt     = w_issue_nxt && (w_k_nxt == '0);
        w_busy_nxt    = (w_state_nxt != IDLE);
        w_err_vld_nxt = (w_state_nxt == DONE);
    end

    assign sel       = r_sel;
    assign sub       = r_sub;
    assign clr_accum = r_clr;
    assign en_accum  = w_en_accum;
    assign busy      = r_busy;
    assign err_vld   = r_err_vld;

endmodule
